// File: rtl/memory_stage_pkg.sv
// Shared bus/stage types (common) and memory-stage types plus helpers (pipes).
// Forwarding is enabled in memory_stage by defining MEMORY_STAGE_FWD_EN.
package common;
    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [31:0] u32;
    typedef logic [7:0]  strobe_t;
    typedef logic [4:0]  creg_addr_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;
endpackage

package pipes;
    import common::*;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        msize_t memsize;
        logic   zeroextwb;
    } control_t;

    typedef struct packed {
        logic       valid;
        addr_t      pc;
        u32         raw_instr;
        control_t   ctl;
        creg_addr_t ra1;
        creg_addr_t ra2;
        creg_addr_t dst;
        word_t      aluout;
        word_t      memwd;
    } execute_data_t;

    typedef struct packed {
        logic       valid;
        addr_t      pc;
        u32         raw_instr;
        control_t   ctl;
        creg_addr_t ra1;
        creg_addr_t ra2;
        creg_addr_t dst;
        word_t      writedata;
        addr_t      memaddr;
    } memory_data_t;

    typedef struct packed {
        logic       enable;
        creg_addr_t dst;
        word_t      data;
    } fwd_data_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } mem_state_t;

    function automatic strobe_t store_strobe(input msize_t size, input logic [2:0] offset);
        strobe_t base;
        base = '0;
        unique case (size)
            MSIZE1: base = 8'h01;
            MSIZE2: base = 8'h03;
            MSIZE4: base = 8'h0F;
            MSIZE8: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic misaligned(input msize_t size, input logic [2:0] offset);
        logic bad;
        bad = 1'b0;
        unique case (size)
            MSIZE1: bad = 1'b0;
            MSIZE2: bad = offset[0];
            MSIZE4: bad = |offset[1:0];
            MSIZE8: bad = |offset;
        endcase
        return bad;
    endfunction

    function automatic word_t extend(input word_t raw, input msize_t size, input logic zeroext);
        word_t r;
        r = raw;
        unique case (size)
            MSIZE1: r = zeroext ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            MSIZE2: r = zeroext ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            MSIZE4: r = zeroext ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            MSIZE8: r = raw;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/memory_stage_readdata.sv
// Load-data alignment: shift the bus word down to the access offset, then extend.
module mem_readdata
    import common::*;
    import pipes::*;
(
    input  word_t      data,
    input  logic [2:0] offset,
    input  msize_t     size,
    input  logic       zeroext,
    output word_t      result
);
    word_t shifted;

    assign shifted = data >> {offset, 3'b000};
    assign result  = extend(shifted, size, zeroext);
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: ALU pass-through, data-bus load/store FSM, writeback hold.
// Define MEMORY_STAGE_FWD_EN to drive fwdM from the registered result.
module memory_stage
    import common::*;
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output logic          stallE,
    output memory_data_t  dataM,
    input  logic          stallW,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output fwd_data_t     fwdM
);
    mem_state_t    state, state_next;
    execute_data_t req, req_next;
    memory_data_t  dm_next;
    memory_data_t  pass_result;
    memory_data_t  mem_result;
    word_t         load_data;
    logic [2:0]    offset;
    logic          dm_stalled;
    logic          is_mem;

    assign offset     = req.aluout[2:0];
    assign dm_stalled = dataM.valid & stallW;
    assign is_mem     = dataE.ctl.memread | dataE.ctl.memwrite;
    assign stallE     = (state != IDLE) | dm_stalled;

    mem_readdata u_readdata (
        .data    (dresp.data),
        .offset  (offset),
        .size    (req.ctl.memsize),
        .zeroext (req.ctl.zeroextwb),
        .result  (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req   <= '0;
            dataM <= '0;
        end else begin
            state <= state_next;
            req   <= req_next;
            dataM <= dm_next;
        end
    end

    always_comb begin
        pass_result           = '0;
        pass_result.valid     = dataE.valid;
        pass_result.pc        = dataE.pc;
        pass_result.raw_instr = dataE.raw_instr;
        pass_result.ctl       = dataE.ctl;
        pass_result.ra1       = dataE.ra1;
        pass_result.ra2       = dataE.ra2;
        pass_result.dst       = dataE.dst;
        pass_result.writedata = dataE.aluout;
        pass_result.memaddr   = dataE.aluout;
    end

    always_comb begin
        mem_result           = '0;
        mem_result.valid     = req.valid;
        mem_result.pc        = req.pc;
        mem_result.raw_instr = req.raw_instr;
        mem_result.ctl       = req.ctl;
        mem_result.ra1       = req.ra1;
        mem_result.ra2       = req.ra2;
        mem_result.dst       = req.dst;
        mem_result.writedata = req.ctl.memread ? load_data : '0;
        mem_result.memaddr   = req.aluout;
    end

    always_comb begin
        state_next = state;
        req_next   = req;
        dm_next    = dataM;
        unique case (state)
            IDLE: begin
                // A pass-through result refused by writeback parks in HOLD.
                if (dm_stalled) begin
                    state_next = HOLD;
                end else if (dataE.valid && is_mem) begin
                    if (misaligned(dataE.ctl.memsize, dataE.aluout[2:0])) begin
                        dm_next              = pass_result;
                        dm_next.writedata    = '0;
                        dm_next.ctl.regwrite = 1'b0;
                        state_next           = HOLD;
                    end else begin
                        req_next   = dataE;
                        dm_next    = '0;
                        state_next = REQ;
                    end
                end else if (dataE.valid) begin
                    dm_next = pass_result;
                end else begin
                    dm_next = '0;
                end
            end
            REQ: begin
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        dm_next    = mem_result;
                        state_next = HOLD;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dresp.data_ok) begin
                    dm_next    = mem_result;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!stallW) begin
                    dm_next    = '0;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = (state == REQ);
        dreq.addr   = req.aluout;
        dreq.size   = req.ctl.memsize;
        dreq.strobe = req.ctl.memwrite ? store_strobe(req.ctl.memsize, offset) : '0;
        dreq.data   = req.memwd << {offset, 3'b000};
    end

`ifdef MEMORY_STAGE_FWD_EN
    assign fwdM.enable = dataM.valid & dataM.ctl.regwrite & (dataM.dst != '0);
    assign fwdM.dst    = dataM.dst;
    assign fwdM.data   = dataM.writedata;
`else
    assign fwdM = '0;
`endif
endmodule
